rx_polar_lock_nx: RTL and testbench

Multi-lane receive polarity and block-lock qualifier for the 64/66 PCS receive path. It sits between the per-lane positive/negative `rx_block_sync` pairs and the descramblers. For each of `LANES` lanes it picks a polarity and qualifies block lock through a debounced confirm/hold state machine. It then outputs registered, polarity-selected 48b data together with a qualified lock. Lock must be confirmed over several cycles and is held through short dropouts, and polarity modes are set per lane.

---
 rtl/rx_polar_lock_nx.sv | 221 ++++++++++++++++++++++
 tb/tb_rx_polar_lock_nx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_polar_lock_nx.sv
// Multi-lane receive polarity picker and block-lock qualifier.
// For each lane, a debounced confirm/hold FSM selects pos or neg sync data
// and produces a qualified block lock. Data and valid are registered.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SEARCH   | no polarity candidate, waiting for a single-sided lock
// CONF_POS | counting consecutive pos-only samples toward lock
// CONF_NEG | counting consecutive neg-only samples toward lock
// LOCK_POS | locked on pos side, tolerating up to LOSS_CNT-1 misses
// LOCK_NEG | locked on neg side, tolerating up to LOSS_CNT-1 misses
// GIVEN    | polarity forced by given_polar, lock = registered raw lock
module rx_polar_lock_nx #(
  parameter int LANES       = 4,
  parameter int WIDTH       = 48,
  parameter int CONFIRM_CNT = 16,
  parameter int LOSS_CNT    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_enable,
  input  logic [LANES-1:0]       infer_polar,
  input  logic [LANES-1:0]       given_polar,
  input  logic [LANES-1:0]       infer_blocklock,
  input  logic [LANES-1:0]       given_blocklock,
  input  logic [LANES-1:0]       in_lock_pos,
  input  logic [LANES-1:0]       in_lock_neg,
  input  logic [LANES*WIDTH-1:0] in_data_pos,
  input  logic [LANES*WIDTH-1:0] in_data_neg,
  input  logic [LANES-1:0]       in_valid_pos,
  input  logic [LANES-1:0]       in_valid_neg,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES-1:0]       out_blocklock,
  output logic [2*LANES-1:0]     out_detectedpolar,
  output logic [LANES-1:0]       out_polar_flip,
  output logic                   out_all_locked
);

  typedef enum logic [2:0] {
    S_SEARCH   = 3'd0,
    S_CONF_POS = 3'd1,
    S_CONF_NEG = 3'd2,
    S_LOCK_POS = 3'd3,
    S_LOCK_NEG = 3'd4,
    S_GIVEN    = 3'd5
  } state_t;

  // Loss counter needs at least one bit even when a single miss drops lock.
  localparam int CW = $clog2(CONFIRM_CNT);
  localparam int LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
  localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

  state_t                 state_q [LANES];
  state_t                 state_d [LANES];
  logic [CW-1:0]          cnt_q   [LANES];
  logic [CW-1:0]          cnt_d   [LANES];
  logic [LW-1:0]          loss_q  [LANES];
  logic [LW-1:0]          loss_d  [LANES];
  logic [LANES-1:0]       last_pol_q, last_pol_d;  // 1 = pos
  logic [LANES-1:0]       glock_q, glock_d;
  logic [LANES-1:0]       flip_q, flip_d;
  logic [LANES-1:0]       valid_q, valid_d;
  logic [LANES*WIDTH-1:0] data_q, data_d;

  logic [LANES-1:0]       pos_only, neg_only;
  logic [LANES-1:0]       qlock, sel_neg, sel_valid;

  assign pos_only = in_lock_pos & ~in_lock_neg;
  assign neg_only = in_lock_neg & ~in_lock_pos;

  // Per-lane decode of the current state: lock, polarity code, data side.
  always_comb begin
    qlock             = '0;
    sel_neg           = '0;
    sel_valid         = '0;
    out_blocklock     = '0;
    out_detectedpolar = '1;
    for (int i = 0; i < LANES; i++) begin
      qlock[i]   = (state_q[i] == S_LOCK_POS) || (state_q[i] == S_LOCK_NEG) ||
                   ((state_q[i] == S_GIVEN) && glock_q[i]);
      sel_neg[i] = (state_q[i] == S_LOCK_NEG) ||
                   ((state_q[i] == S_GIVEN) && !given_polar[i]);
      sel_valid[i]     = sel_neg[i] ? in_valid_neg[i] : in_valid_pos[i];
      out_blocklock[i] = qlock[i] & (infer_blocklock[i] | given_blocklock[i]);
      case (state_q[i])
        S_LOCK_POS: out_detectedpolar[2*i +: 2] = 2'b01;
        S_LOCK_NEG: out_detectedpolar[2*i +: 2] = 2'b00;
        S_GIVEN:    out_detectedpolar[2*i +: 2] = {1'b0, given_polar[i]};
        default:    out_detectedpolar[2*i +: 2] = 2'b11;
      endcase
    end
  end

  // Next-state, counter and output-register logic for every lane.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_d     = loss_q;
    last_pol_d = last_pol_q;
    glock_d    = glock_q;
    data_d     = data_q;
    flip_d     = '0;
    valid_d    = '0;
    if (in_enable) begin
      for (int i = 0; i < LANES; i++) begin
        glock_d[i] = given_polar[i] ? in_lock_pos[i] : in_lock_neg[i];
        data_d[i*WIDTH +: WIDTH] = sel_neg[i] ? in_data_neg[i*WIDTH +: WIDTH]
                                              : in_data_pos[i*WIDTH +: WIDTH];
        valid_d[i] = sel_valid[i] & out_blocklock[i];
        if (!infer_polar[i]) begin
          state_d[i] = S_GIVEN;
          cnt_d[i]   = '0;
          loss_d[i]  = '0;
        end else begin
          case (state_q[i])
            S_GIVEN: begin
              state_d[i] = S_SEARCH;
            end
            S_SEARCH: begin
              if (pos_only[i]) begin
                state_d[i] = S_CONF_POS;
                cnt_d[i]   = CW'(1);
              end else if (neg_only[i]) begin
                state_d[i] = S_CONF_NEG;
                cnt_d[i]   = CW'(1);
              end
            end
            S_CONF_POS: begin
              if (pos_only[i]) begin
                if (cnt_q[i] == CONF_LAST) begin
                  state_d[i]    = S_LOCK_POS;
                  cnt_d[i]      = '0;
                  flip_d[i]     = !last_pol_q[i];
                  last_pol_d[i] = 1'b1;
                end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
                end
              end else if (neg_only[i]) begin
                state_d[i] = S_CONF_NEG;
                cnt_d[i]   = CW'(1);
              end else begin
                state_d[i] = S_SEARCH;
                cnt_d[i]   = '0;
              end
            end
            S_CONF_NEG: begin
              if (neg_only[i]) begin
                if (cnt_q[i] == CONF_LAST) begin
                  state_d[i]    = S_LOCK_NEG;
                  cnt_d[i]      = '0;
                  flip_d[i]     = last_pol_q[i];
                  last_pol_d[i] = 1'b0;
                end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
                end
              end else if (pos_only[i]) begin
                state_d[i] = S_CONF_POS;
                cnt_d[i]   = CW'(1);
              end else begin
                state_d[i] = S_SEARCH;
                cnt_d[i]   = '0;
              end
            end
            S_LOCK_POS, S_LOCK_NEG: begin
              // The locked side alone decides; the other side is ignored.
              if ((state_q[i] == S_LOCK_POS) ? in_lock_pos[i] : in_lock_neg[i]) begin
                loss_d[i] = '0;
              end else if (loss_q[i] == LOSS_LAST) begin
                state_d[i] = S_SEARCH;
                cnt_d[i]   = '0;
                loss_d[i]  = '0;
              end else begin
                loss_d[i] = loss_q[i] + LW'(1);
              end
            end
            default: begin
              state_d[i] = S_SEARCH;
              cnt_d[i]   = '0;
              loss_d[i]  = '0;
            end
          endcase
        end
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= S_SEARCH;
        cnt_q[i]   <= '0;
        loss_q[i]  <= '0;
      end
      last_pol_q <= '1;
      glock_q    <= '0;
      flip_q     <= '0;
      valid_q    <= '0;
      data_q     <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        loss_q[i]  <= loss_d[i];
      end
      last_pol_q <= last_pol_d;
      glock_q    <= glock_d;
      flip_q     <= flip_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign out_data       = data_q;
  assign out_valid      = valid_q;
  assign out_polar_flip = flip_q;
  assign out_all_locked = &out_blocklock;

endmodule

// File: tb/tb_rx_polar_lock_nx.sv
// Randomized bench for rx_polar_lock_nx against a run-length reference model.
module tb_rx_polar_lock_nx;
  localparam int LANES       = 4;
  localparam int WIDTH       = 48;
  localparam int CONFIRM_CNT = 16;
  localparam int LOSS_CNT    = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_enable;
  logic [LANES-1:0]       infer_polar, given_polar, infer_blocklock, given_blocklock;
  logic [LANES-1:0]       in_lock_pos, in_lock_neg, in_valid_pos, in_valid_neg;
  logic [LANES*WIDTH-1:0] in_data_pos, in_data_neg;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid, out_blocklock, out_polar_flip;
  logic [2*LANES-1:0]     out_detectedpolar;
  logic                   out_all_locked;

  always #5 clk = ~clk;

  rx_polar_lock_nx #(
    .LANES(LANES), .WIDTH(WIDTH), .CONFIRM_CNT(CONFIRM_CNT), .LOSS_CNT(LOSS_CNT)
  ) dut (
    .clk(clk), .reset(reset), .in_enable(in_enable),
    .infer_polar(infer_polar), .given_polar(given_polar),
    .infer_blocklock(infer_blocklock), .given_blocklock(given_blocklock),
    .in_lock_pos(in_lock_pos), .in_lock_neg(in_lock_neg),
    .in_data_pos(in_data_pos), .in_data_neg(in_data_neg),
    .in_valid_pos(in_valid_pos), .in_valid_neg(in_valid_neg),
    .out_data(out_data), .out_valid(out_valid), .out_blocklock(out_blocklock),
    .out_detectedpolar(out_detectedpolar), .out_polar_flip(out_polar_flip),
    .out_all_locked(out_all_locked)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lock is -1 (none), 1 (pos) or 0 (neg); run counts the
  // current streak of single-sided samples while unlocked.
  int               m_given [LANES];
  int               m_lock  [LANES];
  int               m_run   [LANES];
  int               m_runp  [LANES];
  int               m_miss  [LANES];
  int               m_last  [LANES];
  bit               m_glock [LANES];
  bit               m_flip  [LANES];
  bit               m_valid [LANES];
  logic [WIDTH-1:0] m_data  [LANES];

  int prof  [LANES];
  int burst [LANES];
  logic [LANES-1:0] obs_blk;
  logic             obs_all;

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_given[l] = 0; m_lock[l] = -1; m_run[l] = 0; m_runp[l] = 0;
      m_miss[l] = 0;  m_last[l] = 1;  m_glock[l] = 0; m_flip[l] = 0;
      m_valid[l] = 0; m_data[l] = '0;
    end
  endtask

  function automatic bit lane_blk(int l);
    bit q;
    q = (m_given[l] != 0) ? m_glock[l] : (m_lock[l] >= 0);
    return q & (infer_blocklock[l] | given_blocklock[l]);
  endfunction

  function automatic bit lane_selneg(int l);
    return (m_given[l] != 0) ? !given_polar[l] : (m_lock[l] == 0);
  endfunction

  task automatic model_step();
    bit p, n, sneg, blk, lx;
    int pol;
    for (int l = 0; l < LANES; l++) begin
      p = in_lock_pos[l];
      n = in_lock_neg[l];
      sneg = lane_selneg(l);
      blk  = lane_blk(l);
      m_flip[l] = 0;
      if (!in_enable) begin
        m_valid[l] = 0;
      end else begin
        m_data[l]  = sneg ? in_data_neg[l*WIDTH +: WIDTH] : in_data_pos[l*WIDTH +: WIDTH];
        m_valid[l] = (sneg ? in_valid_neg[l] : in_valid_pos[l]) & blk;
        m_glock[l] = given_polar[l] ? p : n;
        if (!infer_polar[l]) begin
          m_given[l] = 1; m_lock[l] = -1; m_run[l] = 0; m_miss[l] = 0;
        end else if (m_given[l] != 0) begin
          m_given[l] = 0; m_run[l] = 0;
        end else if (m_lock[l] >= 0) begin
          lx = (m_lock[l] == 1) ? p : n;
          if (lx) m_miss[l] = 0;
          else m_miss[l]++;
          if (m_miss[l] == LOSS_CNT) begin
            m_lock[l] = -1; m_miss[l] = 0; m_run[l] = 0;
          end
        end else begin
          pol = (p && !n) ? 1 : ((n && !p) ? 0 : -1);
          if (pol < 0) m_run[l] = 0;
          else if (m_run[l] > 0 && m_runp[l] == pol) m_run[l]++;
          else begin
            m_run[l] = 1; m_runp[l] = pol;
          end
          if (m_run[l] == CONFIRM_CNT) begin
            m_lock[l] = pol; m_run[l] = 0;
            m_flip[l] = (pol != m_last[l]);
            m_last[l] = pol;
          end
        end
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    logic [LANES-1:0]       e_blk, e_flip, e_valid;
    logic [2*LANES-1:0]     e_code;
    logic [LANES*WIDTH-1:0] e_data;
    for (int l = 0; l < LANES; l++) begin
      e_blk[l]   = lane_blk(l);
      e_flip[l]  = m_flip[l];
      e_valid[l] = m_valid[l];
      e_data[l*WIDTH +: WIDTH] = m_data[l];
      if (m_given[l] != 0)    e_code[2*l +: 2] = {1'b0, given_polar[l]};
      else if (m_lock[l] == 1) e_code[2*l +: 2] = 2'b01;
      else if (m_lock[l] == 0) e_code[2*l +: 2] = 2'b00;
      else                     e_code[2*l +: 2] = 2'b11;
    end
    chk({ph, ".blocklock"}, 256'(out_blocklock), 256'(e_blk));
    chk({ph, ".polar"},     256'(out_detectedpolar), 256'(e_code));
    chk({ph, ".flip"},      256'(out_polar_flip), 256'(e_flip));
    chk({ph, ".valid"},     256'(out_valid), 256'(e_valid));
    chk({ph, ".data"},      256'(out_data), 256'(e_data));
    chk({ph, ".all"},       256'(out_all_locked), 256'(&e_blk));
  endtask

  task automatic gen_lane(input int l);
    bit p, n;
    p = 0; n = 0;
    case (prof[l])
      1: p = 1;
      2: n = 1;
      3: begin p = 1; n = 1; end
      4: begin p = 1'($urandom_range(0, 1)); n = 1'($urandom_range(0, 1)); end
      5: if ($urandom_range(0, 7) == 0) n = 1; else p = 1;
      6, 7: begin
        if (burst[l] > 0) burst[l]--;
        else if ($urandom_range(0, 14) == 0) burst[l] = $urandom_range(0, 5);
        else if (prof[l] == 6) p = 1;
        else n = 1;
      end
      default: ;
    endcase
    in_lock_pos[l] = p;
    in_lock_neg[l] = n;
  endtask

  // One cycle: drive inputs, check at the falling edge, advance the model.
  task automatic run_cycle(input string ph);
    logic [63:0] r;
    for (int l = 0; l < LANES; l++) begin
      gen_lane(l);
      r = {$urandom(), $urandom()};
      in_data_pos[l*WIDTH +: WIDTH] = r[WIDTH-1:0];
      r = {$urandom(), $urandom()};
      in_data_neg[l*WIDTH +: WIDTH] = r[WIDTH-1:0];
      in_valid_pos[l] = ($urandom_range(0, 9) != 0);
      in_valid_neg[l] = ($urandom_range(0, 9) != 0);
    end
    @(negedge clk);
    obs_blk = out_blocklock;
    obs_all = out_all_locked;
    check_outputs(ph);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rise0, rise_all, seglen;
    reset = 1'b1;
    in_enable = 1'b1;
    infer_polar = '1; given_polar = '1; infer_blocklock = '1; given_blocklock = '0;
    in_lock_pos = '0; in_lock_neg = '0; in_valid_pos = '0; in_valid_neg = '0;
    in_data_pos = '0; in_data_neg = '0;
    for (int l = 0; l < LANES; l++) begin prof[l] = 0; burst[l] = 0; end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.polar", 256'(out_detectedpolar), 256'({2*LANES{1'b1}}));
    chk("reset.blocklock", 256'(out_blocklock), 256'(0));
    reset = 1'b0;

    // Staggered lock: lane0 pos from 0, lane1 pos from 5, lane2 neg from 10, lane3 pos from 20.
    rise0 = -1; rise_all = -1;
    for (int c = 0; c < 50; c++) begin
      prof[0] = 1;
      prof[1] = (c >= 5)  ? 1 : 0;
      prof[2] = (c >= 10) ? 2 : 0;
      prof[3] = (c >= 20) ? 1 : 0;
      run_cycle("stagger");
      if (rise0 < 0 && obs_blk[0]) rise0 = c;
      if (rise_all < 0 && obs_all) rise_all = c;
    end
    chk("rise_lane0", 256'(rise0), 256'(CONFIRM_CNT));
    chk("rise_all", 256'(rise_all), 256'(20 + CONFIRM_CNT));

    // Freeze while locked, then resume.
    in_enable = 1'b0;
    repeat (6) run_cycle("freeze");
    in_enable = 1'b1;
    repeat (3) run_cycle("resume");

    // Asynchronous reset pulse away from the clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("areset.blocklock", 256'(out_blocklock), 256'(0));
    chk("areset.polar", 256'(out_detectedpolar), 256'({2*LANES{1'b1}}));
    chk("areset.valid", 256'(out_valid), 256'(0));
    chk("areset.data", 256'(out_data), 256'(0));
    chk("areset.flip", 256'(out_polar_flip), 256'(0));
    chk("areset.all", 256'(out_all_locked), 256'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Given polarity with toggling raw lock, then masked lock.
    infer_polar = '0; given_polar = '0;
    for (int l = 0; l < LANES; l++) prof[l] = 4;
    repeat (20) run_cycle("given");
    infer_blocklock = '0; given_blocklock = '0;
    repeat (10) run_cycle("given_masked");
    infer_blocklock = '1;

    // Both polarities locked while searching.
    infer_polar = '1;
    for (int l = 0; l < LANES; l++) prof[l] = 3;
    repeat (100) run_cycle("both");

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      for (int l = 0; l < LANES; l++) begin
        prof[l]            = $urandom_range(0, 7);
        infer_polar[l]     = ($urandom_range(0, 4) != 0);
        given_polar[l]     = 1'($urandom_range(0, 1));
        infer_blocklock[l] = ($urandom_range(0, 3) != 0);
        given_blocklock[l] = 1'($urandom_range(0, 1));
      end
      seglen = $urandom_range(30, 90);
      for (int c = 0; c < seglen; c++) begin
        in_enable = ($urandom_range(0, 19) != 0);
        run_cycle("random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
